// File: rtl/eight_bit_wallace_product_accumulator_if.sv
// Handshake bundle for the Wallace-tree product accumulator.
// The master side produces 16-bit products and consumes window sums;
// the slave side is the accumulator itself.
`timescale 1ns/1ps

interface eight_bit_wallace_product_accumulator_if #(
  parameter int ACC_W = 24
);
  logic [15:0]      prod_in;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  modport master (
    output prod_in,
    output in_valid,
    output clear,
    output out_ready,
    input  in_ready,
    input  acc_out,
    input  out_valid,
    input  ovf
  );

  modport slave (
    input  prod_in,
    input  in_valid,
    input  clear,
    input  out_ready,
    output in_ready,
    output acc_out,
    output out_valid,
    output ovf
  );
endinterface

// File: rtl/eight_bit_wallace_product_accumulator.sv
// Accumulates N_ACC unsigned 16-bit products (output of an 8x8 Wallace
// reduction) into an ACC_W-bit window sum and presents it with a
// valid/ready handshake. Each accepted product sits one cycle in a pipe
// register before being added, so the final sum appears two cycles after
// the last accept.
//
// Build option: WALLACE_ACC_SATURATE_EN
//   defined   -> an overflowing add clamps the accumulator to all-ones
//   undefined -> an overflowing add wraps modulo 2^ACC_W
//   Either way ovf is set and stays set until transfer, clear or reset.
`timescale 1ns/1ps

module eight_bit_wallace_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int N_ACC = 16
) (
  input logic clk,
  input logic rst_n,
  eight_bit_wallace_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Window length as an 8-bit count target; N_ACC never exceeds 255, so the
  // counter can never wrap before it reaches the target.
  localparam logic [7:0] N_ACC_U8 = 8'(N_ACC);

  state_t           state_reg;
  state_t           state_next;

  // Held low through reset and for the first edge after it, so in_ready only
  // rises on the first clock edge after rst_n deasserts.
  logic             ready_en_reg;

  logic [15:0]      pipe_reg;
  logic [15:0]      pipe_next;
  logic             pipe_valid_reg;
  logic             pipe_valid_next;

  logic [7:0]       count_reg;
  logic [7:0]       count_next;

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_reg;
  logic             ovf_next;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_full;

  logic             in_ready_int;
  logic             accept;
  logic             last_accept;
  logic             transfer;

  // Zero-extend the piped product to accumulator width.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_prod_ext
      if (gi < 16) begin : g_bit
        assign prod_ext[gi] = pipe_reg[gi];
      end else begin : g_pad
        assign prod_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // One extra bit captures the carry out of the add for overflow detection.
  assign sum_full = {1'b0, acc_reg} + {1'b0, prod_ext};

  // Input side accepts only while the window is still open.
  assign in_ready_int = ready_en_reg && ((state_reg == IDLE) || (state_reg == ACCUM));
  assign accept       = bus.in_valid && in_ready_int;
  assign last_accept  = accept && ((count_reg + 8'd1) == N_ACC_U8);
  assign transfer     = (state_reg == HOLD) && bus.out_ready;

  assign bus.in_ready = in_ready_int;
  assign bus.acc_out  = acc_reg;
  assign bus.ovf      = ovf_reg;

  // State register; reset drops any partial window immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake output decode; clear overrides every transition.
  always_comb begin
    state_next    = state_reg;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE, ACCUM: begin
        if (last_accept) begin
          state_next = DRAIN;
        end else if (accept) begin
          state_next = ACCUM;
        end
      end
      DRAIN: begin
        state_next = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (transfer) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.clear) begin
      state_next = IDLE;
    end
  end

  // Datapath next-values: pipe load, accumulate with overflow handling,
  // window restart on transfer, and abort on clear.
  always_comb begin
    pipe_next       = accept ? bus.prod_in : 16'd0;
    pipe_valid_next = accept;
    count_next      = accept ? (count_reg + 8'd1) : count_reg;
    acc_next        = acc_reg;
    ovf_next        = ovf_reg;

    if (pipe_valid_reg) begin
      if (sum_full[ACC_W]) begin
        ovf_next = 1'b1;
`ifdef WALLACE_ACC_SATURATE_EN
        acc_next = {ACC_W{1'b1}};
`else
        acc_next = sum_full[ACC_W-1:0];
`endif
      end else begin
        acc_next = sum_full[ACC_W-1:0];
      end
    end

    // The pipe is always empty in HOLD, so restarting here loses nothing.
    if (transfer) begin
      acc_next   = '0;
      count_next = 8'd0;
      ovf_next   = 1'b0;
    end

    // A product accepted in the clear cycle is dropped along with the window.
    if (bus.clear) begin
      pipe_next       = 16'd0;
      pipe_valid_next = 1'b0;
      count_next      = 8'd0;
      acc_next        = '0;
      ovf_next        = 1'b0;
    end
  end

  // Datapath registers with asynchronous reset to an empty window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg   <= 1'b0;
      pipe_reg       <= 16'd0;
      pipe_valid_reg <= 1'b0;
      count_reg      <= 8'd0;
      acc_reg        <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      ready_en_reg   <= 1'b1;
      pipe_reg       <= pipe_next;
      pipe_valid_reg <= pipe_valid_next;
      count_reg      <= count_next;
      acc_reg        <= acc_next;
      ovf_reg        <= ovf_next;
    end
  end

endmodule

// File: tb/tb_eight_bit_wallace_product_accumulator.sv
// Self-checking bench for the Wallace product accumulator.
// Two N_ACC=4 instances (ACC_W=24 and ACC_W=17) run in lockstep on shared
// stimulus; a third instance (N_ACC=1) gets its own short sequences.
`timescale 1ns/1ps

module tb_eight_bit_wallace_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [15:0] prod = 16'd0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic [15:0] c_prod = 16'd0;
  logic        c_valid = 1'b0;
  logic        c_clear = 1'b0;
  logic        c_out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eight_bit_wallace_product_accumulator_if #(.ACC_W(24)) if_a ();
  eight_bit_wallace_product_accumulator_if #(.ACC_W(17)) if_b ();
  eight_bit_wallace_product_accumulator_if #(.ACC_W(24)) if_c ();

  assign if_a.prod_in   = prod;
  assign if_a.in_valid  = in_valid;
  assign if_a.clear     = clear;
  assign if_a.out_ready = out_ready;
  assign if_b.prod_in   = prod;
  assign if_b.in_valid  = in_valid;
  assign if_b.clear     = clear;
  assign if_b.out_ready = out_ready;
  assign if_c.prod_in   = c_prod;
  assign if_c.in_valid  = c_valid;
  assign if_c.clear     = c_clear;
  assign if_c.out_ready = c_out_ready;

  eight_bit_wallace_product_accumulator #(.ACC_W(24), .N_ACC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  eight_bit_wallace_product_accumulator #(.ACC_W(17), .N_ACC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );
  eight_bit_wallace_product_accumulator #(.ACC_W(24), .N_ACC(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );

  typedef struct {
    logic [3:0][15:0] p;
    int               gap;
    int               stall;
    logic [31:0]      exp_a;
    logic [31:0]      exp_b;
    logic             exp_ovf_b;
    string            tag;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mk(input logic [15:0] p0, input logic [15:0] p1,
                                          input logic [15:0] p2, input logic [15:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  // Window-sum reference: sum of products in plain arithmetic, then the
  // build's overflow rule applied to the true total.
  function automatic void model(input int total, input int w,
                                output logic [31:0] acc, output logic ovf);
    longint mx;
    mx  = (longint'(1) << w) - 1;
    ovf = (longint'(total) > mx);
`ifdef WALLACE_ACC_SATURATE_EN
    acc = ovf ? 32'(mx) : 32'(total);
`else
    acc = 32'(longint'(total) & mx);
`endif
  endfunction

  // Feed one four-product window to A/B, check DRAIN, HOLD, stall
  // stability and the transfer; a product is offered on a stalled transfer.
  task automatic run_window(input logic [3:0][15:0] p, input int gap, input int stall,
                            input logic [31:0] exp_a, input logic exp_ovf_a,
                            input logic [31:0] exp_b, input logic exp_ovf_b,
                            input string tag);
    int wait_cnt;
    out_ready = (stall == 0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      prod = p[i];
      in_valid = 1'b1;
      wait_cnt = 0;
      while (!if_a.in_ready && wait_cnt < 50) begin
        @(posedge clk); #1;
        wait_cnt++;
      end
      if (!if_a.in_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s ready_timeout: in_ready=0 after %0d cycles, required 1", tag, wait_cnt);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    prod = 16'd0;
    check({tag, "_drain_out_valid_a"}, if_a.out_valid, 1'b0);
    check({tag, "_drain_out_valid_b"}, if_b.out_valid, 1'b0);
    check({tag, "_drain_in_ready"}, if_a.in_ready, 1'b0);
    @(posedge clk); #1;
    check({tag, "_hold_out_valid_a"}, if_a.out_valid, 1'b1);
    check({tag, "_hold_out_valid_b"}, if_b.out_valid, 1'b1);
    check({tag, "_acc_a"}, if_a.acc_out, exp_a);
    check({tag, "_acc_b"}, if_b.acc_out, exp_b);
    check({tag, "_ovf_a"}, if_a.ovf, exp_ovf_a);
    check({tag, "_ovf_b"}, if_b.ovf, exp_ovf_b);
    $display("window %s: acc_a=0x%06h ovf_a=%0d acc_b=0x%05h ovf_b=%0d",
             tag, if_a.acc_out, if_a.ovf, if_b.acc_out, if_b.ovf);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_stall_out_valid"}, if_a.out_valid, 1'b1);
      check({tag, "_stall_acc_a"}, if_a.acc_out, exp_a);
      check({tag, "_stall_acc_b"}, if_b.acc_out, exp_b);
      check({tag, "_stall_ovf_b"}, if_b.ovf, exp_ovf_b);
      check({tag, "_stall_in_ready"}, if_a.in_ready, 1'b0);
    end
    if (stall > 0) begin
      out_ready = 1'b1;
      prod = 16'hBEEF;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    prod = 16'd0;
    check({tag, "_post_out_valid"}, if_a.out_valid, 1'b0);
    check({tag, "_post_acc_a"}, if_a.acc_out, 32'd0);
    check({tag, "_post_acc_b"}, if_b.acc_out, 32'd0);
    check({tag, "_post_ovf_b"}, if_b.ovf, 1'b0);
    check({tag, "_post_in_ready"}, if_a.in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] rp;
    int               total;
    logic [31:0]      ea;
    logic [31:0]      eb;
    logic             oa;
    logic             ob;

    tbl[0] = '{mk(16'hFFFF, 16'h0001, 16'h1234, 16'h0000), 0, 0, 32'h011234, 32'h11234, 1'b0, "basic"};
    tbl[1] = '{mk(16'h00FF, 16'h0100, 16'h8000, 16'h7FFF), 0, 5, 32'h0101FE, 32'h101FE, 1'b0, "stall5"};
    tbl[2] = '{mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 2, 0, 32'h000000, 32'h00000, 1'b0, "zeros_gap"};
    tbl[3] = '{mk(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000), 1, 1, 32'h01FFFF, 32'h1FFFF, 1'b0, "at_max"};
`ifdef WALLACE_ACC_SATURATE_EN
    tbl[4] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 0, 32'h03FFFC, 32'h1FFFF, 1'b1, "all_ones"};
    tbl[5] = '{mk(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000), 0, 2, 32'h020000, 32'h1FFFF, 1'b1, "max_plus1"};
`else
    tbl[4] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 0, 32'h03FFFC, 32'h1FFFC, 1'b1, "all_ones"};
    tbl[5] = '{mk(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000), 0, 2, 32'h020000, 32'h00000, 1'b1, "max_plus1"};
`endif

    // Reset state
    #2;
    check("rst_acc_a", if_a.acc_out, 32'd0);
    check("rst_ovf_a", if_a.ovf, 1'b0);
    check("rst_out_valid_a", if_a.out_valid, 1'b0);
    check("rst_in_ready_a", if_a.in_ready, 1'b0);
    check("rst_in_ready_c", if_c.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_release_in_ready", if_a.in_ready, 1'b0);
    @(posedge clk); #1;
    check("first_edge_in_ready", if_a.in_ready, 1'b1);

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      run_window(tbl[v].p, tbl[v].gap, tbl[v].stall, tbl[v].exp_a, 1'b0,
                 tbl[v].exp_b, tbl[v].exp_ovf_b, tbl[v].tag);
    end

    // clear on the third accept
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prod = 16'h0100 * 16'(i + 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_acc_a", if_a.acc_out, 32'h000100);
    prod = 16'h0300;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_acc_a", if_a.acc_out, 32'd0);
    check("clear_in_ready", if_a.in_ready, 1'b1);
    check("clear_out_valid", if_a.out_valid, 1'b0);
    @(posedge clk); #1;
    check("clear_pipe_dropped_a", if_a.acc_out, 32'd0);
    check("clear_pipe_dropped_b", if_b.acc_out, 32'd0);
    run_window(mk(16'd1, 16'd2, 16'd3, 16'd4), 0, 0, 32'd10, 1'b0, 32'd10, 1'b0, "after_clear");

    // reset during DRAIN
    for (int i = 0; i < 4; i++) begin
      prod = 16'h1111;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("drain_in_ready", if_a.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_drain_out_valid", if_a.out_valid, 1'b0);
    check("rst_drain_acc", if_a.acc_out, 32'd0);
    check("rst_drain_in_ready", if_a.in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_drain_no_pulse", if_a.out_valid, 1'b0);
    end
    rst_n = 1'b1;
    check("rst2_release_in_ready", if_a.in_ready, 1'b0);
    @(posedge clk); #1;
    check("rst2_first_edge_in_ready", if_a.in_ready, 1'b1);
    check("rst2_out_valid", if_a.out_valid, 1'b0);
    run_window(mk(16'h10, 16'h20, 16'h30, 16'h40), 0, 0, 32'hA0, 1'b0, 32'hA0, 1'b0, "after_reset");

    // Randomized windows against the reference model
    for (int w = 0; w < 25; w++) begin
      total = 0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) rp[i] = 16'(16'hFFFF - 16'($urandom_range(0, 15)));
        else                           rp[i] = 16'($urandom);
        total += int'(rp[i]);
      end
      model(total, 24, ea, oa);
      model(total, 17, eb, ob);
      run_window(rp, $urandom_range(0, 2), $urandom_range(0, 3), ea, oa, eb, ob,
                 $sformatf("rand%0d", w));
    end

    // N_ACC=1: single product goes IDLE->DRAIN->HOLD
    c_out_ready = 1'b1;
    c_prod = 16'h00A5;
    c_valid = 1'b1;
    check("c_in_ready_idle", if_c.in_ready, 1'b1);
    @(posedge clk); #1;
    c_valid = 1'b0;
    check("c_drain_out_valid", if_c.out_valid, 1'b0);
    check("c_drain_in_ready", if_c.in_ready, 1'b0);
    @(posedge clk); #1;
    check("c_hold_out_valid", if_c.out_valid, 1'b1);
    check("c_acc", if_c.acc_out, 32'h0000A5);
    $display("window c_single: acc_c=0x%06h", if_c.acc_out);
    @(posedge clk); #1;
    check("c_post_out_valid", if_c.out_valid, 1'b0);
    check("c_post_in_ready", if_c.in_ready, 1'b1);

    // N_ACC=1: clear in HOLD discards without out_ready
    c_out_ready = 1'b0;
    c_prod = 16'h0033;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(posedge clk); #1;
    check("c2_hold_acc", if_c.acc_out, 32'h33);
    c_clear = 1'b1;
    @(posedge clk); #1;
    c_clear = 1'b0;
    check("c2_clear_out_valid", if_c.out_valid, 1'b0);
    check("c2_clear_acc", if_c.acc_out, 32'd0);
    check("c2_clear_in_ready", if_c.in_ready, 1'b1);
    c_out_ready = 1'b1;
    c_prod = 16'h0011;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(posedge clk); #1;
    check("c3_acc", if_c.acc_out, 32'h11);
    check("c3_out_valid", if_c.out_valid, 1'b1);
    $display("window c_after_clear: acc_c=0x%06h", if_c.acc_out);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eight_bit_wallace_product_accumulator.md
EIGHT_BIT_WALLACE_PRODUCT_ACCUMULATOR -- requirements
Module: eight_bit_wallace_product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24: accumulator width in bits, legal range 17..32.
REQ-002 The block SHALL have parameter N_ACC, default 16: number of products in one accumulation window, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port prod_in, input, 16 bits: unsigned 8x8 product from the final reduction layer, bit k of weight 2^k.
REQ-006 The block SHALL have port in_valid, input, 1 bit: prod_in is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts prod_in this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous abort of the current window.
REQ-009 The block SHALL have port acc_out, output, ACC_W bits: window sum, valid while out_valid is high.
REQ-010 The block SHALL have port out_valid, output, 1 bit: acc_out holds a completed window sum.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes acc_out.
REQ-012 The block SHALL have port ovf, output, 1 bit: sticky overflow flag for the current window.

Function
REQ-013 The block SHALL accept a product on every cycle where in_valid and in_ready are both high.
REQ-014 The block SHALL register each accepted product in a one-deep pipe register and add it, zero-extended, to the accumulator on the following rising edge.
REQ-015 The block SHALL implement states IDLE (empty window), ACCUM (window partly filled), DRAIN (last product in pipe) and HOLD (result presented).
REQ-016 State transitions SHALL be:
- IDLE->ACCUM on the first accept when N_ACC>1, or IDLE->DRAIN when N_ACC=1.
- ACCUM->DRAIN on the accept that makes the count equal N_ACC.
- DRAIN->HOLD unconditionally.
- HOLD->IDLE on out_valid and out_ready.
REQ-017 in_ready SHALL be high in IDLE and ACCUM, and low in DRAIN and HOLD.
REQ-018 out_valid SHALL be high only in HOLD; acc_out and ovf SHALL stay stable throughout HOLD.
REQ-019 The last product accepted on cycle t SHALL be included in acc_out, with out_valid high from cycle t+2.
REQ-020 On the HOLD->IDLE transfer, the accumulator, count and ovf SHALL return to zero.
REQ-021 A product offered in the same cycle as the transfer SHALL NOT be accepted, because in_ready is low in HOLD.
REQ-022 clear SHALL take priority over every other event: accumulator, pipe, count and ovf go to zero, the state goes to IDLE, and any product accepted in that cycle is discarded.
REQ-023 clear asserted in HOLD SHALL discard the result without requiring out_ready.
REQ-024 The product counter SHALL be 8 bits wide and SHALL never wrap, since N_ACC is at most 255.

Reset
REQ-025 While rst_n is low, the block SHALL asynchronously force state IDLE, acc_out=0, ovf=0, out_valid=0, the pipe register and count to 0, and in_ready=0.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-window or in HOLD SHALL discard all partial results, with no output pulse.

Configuration
REQ-028 The macro WALLACE_ACC_SATURATE_EN SHALL select the overflow behaviour.
- Defined: an add whose true sum exceeds 2^ACC_W-1 clamps the accumulator to all-ones and sets ovf.
- Undefined: the sum wraps modulo 2^ACC_W and sets ovf.
- In both builds ovf stays set until transfer, clear or reset.

Verification (ACC_W=24, N_ACC=4 unless stated)
REQ-029 Products 0xFFFF, 0x0001, 0x1234, 0x0000 on back-to-back cycles, out_ready=1 -> acc_out=0x011234, out_valid high exactly 1 cycle, 2 cycles after the last accept.
REQ-030 Window complete with out_ready=0 for 5 cycles -> in_ready=0 and acc_out stable throughout; the product offered at the transfer cycle is not accepted; the next window starts from 0.
REQ-031 clear pulsed on the cycle of the 3rd accept -> state IDLE, acc_out=0; the next 4 products 1,2,3,4 give acc_out=10.
REQ-032 rst_n pulled low during DRAIN -> out_valid=0 immediately and never rises for that window; the post-reset window sums correctly.
REQ-033 ACC_W=17, four products of 0xFFFF -> with the macro, acc_out=0x1FFFF and ovf=1; without it, acc_out=0x3FFFC mod 2^17=0x1FFFC and ovf=1.
REQ-034 N_ACC=1 with product 0x00A5 -> IDLE->DRAIN->HOLD and acc_out=0x0000A5.
